// File: rtl/chunked_word_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_word_adder_if
//
// Purpose: groups the operand-side and result-side valid/ready handshakes of
// chunked_word_adder into a single bundle.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The sender holds its payload
// stable while valid is high and ready is low.
//
// Signals:
//   in_valid  producer -> adder   A/B/Cin valid
//   in_ready  adder -> producer   adder can accept an operation
//   A, B      producer -> adder   WIDTH-bit addends
//   Cin       producer -> adder   carry-in
//   out_valid adder -> consumer   S/Cout/Ovf valid
//   out_ready consumer -> adder   consumer accepts the result
//   S         adder -> consumer   WIDTH-bit sum, mod 2^WIDTH
//   Cout      adder -> consumer   unsigned carry out of the MSB
//   Ovf       adder -> consumer   two's complement overflow
//
// Modports: slave = the adder, master = the environment driving it.
// ---------------------------------------------------------------------------
interface chunked_word_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/chunked_word_adder.sv
// ---------------------------------------------------------------------------
// chunked_word_adder
//
// Purpose: computes S = A + B + Cin over WIDTH bits with one CHUNK-bit adder
// slice, one chunk per clock, least significant chunk first. An operation
// accepted on edge k yields out_valid after edge k+NCHUNK. The result is held
// until the consumer takes it.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  chunked_word_adder_if.slave (operand and result handshakes)
//
// Parameters:
//   WIDTH  operand/sum width, a multiple of CHUNK
//   CHUNK  bits added per cycle, 1..WIDTH
//
// The FSM state is held in 'state' (type state_t) for hierarchical observation.
// ---------------------------------------------------------------------------
module chunked_word_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    chunked_word_adder_if.slave    bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    // The index needs at least one bit even when there is a single chunk.
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic             cout_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;

    // The single adder slice works on the chunk selected by idx.
    assign slice_a    = a_reg[idx*CHUNK +: CHUNK];
    assign slice_b    = b_reg[idx*CHUNK +: CHUNK];
    assign slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_reg};
    assign last_chunk = (state == RUN) && (idx == LAST_IDX);

    // Next-state logic.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs are flops loaded from the next state, so they never
    // depend combinationally on the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            in_ready_reg  <= (state_next == IDLE);
            out_valid_reg <= (state_next == DONE);
        end
    end

    // Datapath: capture on accept, one chunk per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.A;
            b_reg     <= bus.B;
            carry_reg <= bus.Cin;
            idx       <= '0;
        end else if (state == RUN) begin
            s_reg[idx*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
            carry_reg                 <= slice_sum[CHUNK];
            if (last_chunk) begin
                // The top bit of this slice is the MSB of the final sum.
                cout_reg <= slice_sum[CHUNK];
                ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.S         = s_reg;
    assign bus.Cout      = cout_reg;
    assign bus.Ovf       = ovf_reg;
endmodule

// File: tb/tb_chunked_word_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_word_adder
//
// Purpose: directed checks of chunked_word_adder in three configurations:
// 16/4 (four chunks), 4/1 (exhaustive sweep) and 8/8 (single chunk).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_chunked_word_adder;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    chunked_word_adder_if #(.WIDTH(16)) b16 ();
    chunked_word_adder_if #(.WIDTH(4))  b4  ();
    chunked_word_adder_if #(.WIDTH(8))  b8  ();

    chunked_word_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
    chunked_word_adder #(.WIDTH(4),  .CHUNK(1)) u4  (.clk(clk), .rst(rst), .bus(b4));
    chunked_word_adder #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst(rst), .bus(b8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = 16/4, 1 = 4/1, 2 = 8/8
    task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic v);
        case (sel)
            0: begin b16.A = a;       b16.B = b;       b16.Cin = cin; b16.in_valid = v; end
            1: begin b4.A  = a[3:0];  b4.B  = b[3:0];  b4.Cin  = cin; b4.in_valid  = v; end
            default: begin b8.A = a[7:0]; b8.B = b[7:0]; b8.Cin = cin; b8.in_valid = v; end
        endcase
    endtask

    task automatic set_ready(input int sel, input logic r);
        case (sel)
            0:       b16.out_ready = r;
            1:       b4.out_ready  = r;
            default: b8.out_ready  = r;
        endcase
    endtask

    // {in_ready, out_valid, Cout, Ovf, S zero-extended to 16 bits}
    function automatic logic [19:0] get_obs(input int sel);
        case (sel)
            0:       return {b16.in_ready, b16.out_valid, b16.Cout, b16.Ovf, b16.S};
            1:       return {b4.in_ready, b4.out_valid, b4.Cout, b4.Ovf, 12'h000, b4.S};
            default: return {b8.in_ready, b8.out_valid, b8.Cout, b8.Ovf, 8'h00, b8.S};
        endcase
    endfunction

    // One full operation with out_ready high: checks latency, result and release.
    task automatic op(input int sel, input int nch, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] es, input logic ec, input logic eo,
                      input string tag);
        logic [19:0] o;
        set_ready(sel, 1'b1);
        drive(sel, a, b, cin, 1'b1);
        tick();                                    // accept edge
        drive(sel, ~a, ~b, ~cin, 1'b0);            // operands may change after accept
        for (int i = 1; i <= nch; i++) begin
            tick();
            o = get_obs(sel);
            chk({tag, " out_valid latency"}, 32'(o[18]), 32'(i == nch));
        end
        chk({tag, " S"},        32'(o[15:0]), 32'(es));
        chk({tag, " Cout"},     32'(o[17]),   32'(ec));
        chk({tag, " Ovf"},      32'(o[16]),   32'(eo));
        chk({tag, " in_ready busy"}, 32'(o[19]), 32'd0);
        tick();                                    // result handshake edge
        o = get_obs(sel);
        chk({tag, " out_valid drop"}, 32'(o[18]), 32'd0);
        chk({tag, " in_ready back"},  32'(o[19]), 32'd1);
    endtask

    initial begin
        logic [19:0] o;
        logic [4:0]  s5;
        logic [3:0]  av;
        logic [3:0]  bv;
        logic        eo;

        // ---- reset ----
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive(s, 16'h0, 16'h0, 1'b0, 1'b0);
            set_ready(s, 1'b0);
        end
        tick();
        tick();
        o = get_obs(0);
        chk("rst in_ready",  32'(o[19]), 32'd1);
        chk("rst out_valid", 32'(o[18]), 32'd0);
        chk("rst S",         32'(o[15:0]), 32'h0);
        chk("rst Cout",      32'(o[17]), 32'd0);
        chk("rst Ovf",       32'(o[16]), 32'd0);
        rst = 1'b0;
        tick();
        o = get_obs(0);
        chk("post rst in_ready",  32'(o[19]), 32'd1);
        chk("post rst out_valid", 32'(o[18]), 32'd0);

        // ---- 16/4 directed ----
        op(0, 4, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ffff+1");
        op(0, 4, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, "7fff+0+1");
        op(0, 4, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "8000+8000");

        // ---- 16/4 backpressure, in_valid pulsed during RUN and DONE ----
        set_ready(0, 1'b0);
        drive(0, 16'h1234, 16'h4321, 1'b1, 1'b1);
        tick();                                    // accept
        drive(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);  // must be ignored
        for (int i = 1; i <= 4; i++) begin
            tick();
            o = get_obs(0);
            chk("bp run in_ready", 32'(o[19]), 32'd0);
            chk("bp run out_valid", 32'(o[18]), 32'(i == 4));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            o = get_obs(0);
            chk("bp hold out_valid", 32'(o[18]), 32'd1);
            chk("bp hold in_ready",  32'(o[19]), 32'd0);
            chk("bp hold S",         32'(o[15:0]), 32'h5556);
            chk("bp hold Cout",      32'(o[17]), 32'd0);
            chk("bp hold Ovf",       32'(o[16]), 32'd0);
        end
        drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
        set_ready(0, 1'b1);
        tick();
        o = get_obs(0);
        chk("bp release out_valid", 32'(o[18]), 32'd0);
        chk("bp release in_ready",  32'(o[19]), 32'd1);

        // ---- 16/4 reset two cycles into RUN ----
        drive(0, 16'h1234, 16'h1111, 1'b0, 1'b1);
        tick();                                    // accept
        drive(0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        o = get_obs(0);
        chk("abort out_valid", 32'(o[18]), 32'd0);
        chk("abort S",         32'(o[15:0]), 32'h0);
        chk("abort in_ready",  32'(o[19]), 32'd1);
        chk("abort Cout",      32'(o[17]), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            o = get_obs(0);
            chk("abort no out_valid", 32'(o[18]), 32'd0);
        end
        op(0, 4, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, "1234+1111");

        // ---- 4/1 exhaustive sweep ----
        for (int c = 0; c < 2; c++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    av = 4'(ia);
                    bv = 4'(ib);
                    s5 = 5'(av) + 5'(bv) + 5'(c);
                    eo = (av[3] == bv[3]) && (s5[3] != av[3]);
                    op(1, 4, {12'h0, av}, {12'h0, bv}, c[0], {12'h0, s5[3:0]}, s5[4], eo, "sweep");
                end
            end
        end

        // ---- 8/8 single chunk ----
        op(2, 1, 16'h00C8, 16'h0064, 1'b1, 16'h002D, 1'b1, 1'b0, "c8+64+1");
        op(2, 1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, "7f+01");

        // Back-to-back with in_valid and out_ready held high: accept every 3 cycles.
        set_ready(2, 1'b1);
        drive(2, 16'h00C8, 16'h0064, 1'b1, 1'b1);
        tick();                                    // first accept
        for (int p = 0; p < 9; p++) begin
            o = get_obs(2);
            chk("b2b in_ready",  32'(o[19]), 32'((p % 3) == 2));
            chk("b2b out_valid", 32'(o[18]), 32'((p % 3) == 1));
            if ((p % 3) == 1) begin
                chk("b2b S", 32'(o[15:0]), 32'h2D);
            end
            if (p < 8) begin
                tick();
            end
        end
        drive(2, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        o = get_obs(2);
        chk("b2b idle in_ready", 32'(o[19]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
